// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Purpose  : Shared width helpers and saturation bounds for fixed-point blocks
// Revision : 1.0
// ============================================================================
package fp_pkg;

    localparam int c_SAT_W = 64;
    localparam int c_CNT_W = 8;

    typedef logic signed [c_SAT_W-1:0] sat_t;

    function automatic int fp_max(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // Two guard integer bits keep a difference of mixed-sign operands exact.
    function automatic int fp_wi(input int i1, input int i2);
        return fp_max(i1, i2) + 2;
    endfunction

    function automatic int fp_wf(input int f1, input int f2);
        return fp_max(f1, f2);
    endfunction

    function automatic int fp_w(input int i1, input int f1, input int i2, input int f2);
        return fp_wi(i1, i2) + fp_wf(f1, f2);
    endfunction

    function automatic sat_t sat_max(input int n);
        return (sat_t'(1) <<< (n - 1)) - sat_t'(1);
    endfunction

    function automatic sat_t sat_min(input int n);
        return ~sat_max(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_sub_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_sub_pipe_if
// Purpose  : Operand/result stream bundle for the fixed-point subtractor
// Revision : 1.0
// ============================================================================
interface fp_sub_pipe_if
    import fp_pkg::*;
#(
    parameter int I1 = 2,
    parameter int F1 = 14,
    parameter int I2 = 2,
    parameter int F2 = 14,
    parameter int I3 = 2,
    parameter int F3 = 14
);
    logic                in_valid;
    logic                in_ready;
    logic [I1+F1-1:0]    a;
    logic                s1;
    logic [I2+F2-1:0]    b;
    logic                s2;
    logic                out_valid;
    logic                out_ready;
    logic [I3+F3-1:0]    c;
    logic                sign;
    logic                overflow;
    logic                underflow;
    logic [c_CNT_W-1:0]  ovf_count;
    logic                ovf_clr;

    modport master (
        output in_valid, a, s1, b, s2, out_ready, ovf_clr,
        input  in_ready, out_valid, c, sign, overflow, underflow, ovf_count
    );

    modport slave (
        input  in_valid, a, s1, b, s2, out_ready, ovf_clr,
        output in_ready, out_valid, c, sign, overflow, underflow, ovf_count
    );

endinterface
`default_nettype wire

// File: rtl/fp_sat.sv
`default_nettype none
// ============================================================================
// Module   : fp_sat
// Purpose  : Floor-truncate / zero-pad and saturate a W-bit signed value to Q(I3).F3
// Revision : 1.0
// ============================================================================
module fp_sat
    import fp_pkg::*;
#(
    parameter int W  = 18,
    parameter int WF = 14,
    parameter int I3 = 2,
    parameter int F3 = 14
) (
    input  logic [W-1:0]     i_d,
    output logic [I3+F3-1:0] o_c,
    output logic             o_overflow,
    output logic             o_underflow
);
    localparam int   c_N   = I3 + F3;
    localparam int   c_TW  = (F3 < WF) ? W - (WF - F3) : W + (F3 - WF);
    localparam sat_t c_MAX = sat_max(c_N);
    localparam sat_t c_MIN = sat_min(c_N);

    logic [c_TW-1:0] w_t;
    logic            w_lost;
    sat_t            w_t_ext;

    generate
        if (F3 < WF) begin : g_trunc
            // Dropping low bits of a two's-complement value floors toward -inf.
            assign w_t    = i_d[W-1:WF-F3];
            assign w_lost = |i_d[WF-F3-1:0];
        end else if (F3 == WF) begin : g_exact
            assign w_t    = i_d;
            assign w_lost = 1'b0;
        end else begin : g_pad
            assign w_t    = {i_d, {(F3-WF){1'b0}}};
            assign w_lost = 1'b0;
        end
    endgenerate

    assign w_t_ext = sat_t'($signed(w_t));

    always_comb begin
        o_c         = w_t_ext[c_N-1:0];
        o_overflow  = 1'b0;
        o_underflow = w_lost;
        if (w_t_ext > c_MAX) begin
            o_c         = c_MAX[c_N-1:0];
            o_overflow  = 1'b1;
            o_underflow = 1'b0;
        end else if (w_t_ext < c_MIN) begin
            o_c         = c_MIN[c_N-1:0];
            o_overflow  = 1'b1;
            o_underflow = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_sub_pipe
// Purpose  : 3-stage valid/ready fixed-point subtractor c = a - b with sat flags
// Revision : 1.0
// ============================================================================
module fp_sub_pipe
    import fp_pkg::*;
#(
    parameter int I1 = 2,
    parameter int F1 = 14,
    parameter int I2 = 2,
    parameter int F2 = 14,
    parameter int I3 = 2,
    parameter int F3 = 14
) (
    input  logic          clk,
    input  logic          rst,
    fp_sub_pipe_if.slave  bus
);
    localparam int c_WF = fp_wf(F1, F2);
    localparam int c_W  = fp_w(I1, F1, I2, F2);
    localparam int c_N  = I3 + F3;

    logic [c_W-1:0]     w_a_ext, w_b_ext, w_a_al, w_b_al;
    logic [c_N-1:0]     w_c;
    logic               w_ovf, w_unf, w_stall;

    logic               r_v1, r_v2, r_v3;
    logic [c_W-1:0]     r_a_al, r_b_al, r_d;
    logic [c_N-1:0]     r_c;
    logic               r_ovf, r_unf;
    logic [c_CNT_W-1:0] r_cnt;

    // A stalled output freezes the whole pipe; bubbles are kept in place.
    assign w_stall      = r_v3 && !bus.out_ready;
    assign bus.in_ready = !w_stall;

    assign w_a_ext = {{(c_W-I1-F1){bus.s1 & bus.a[I1+F1-1]}}, bus.a};
    assign w_b_ext = {{(c_W-I2-F2){bus.s2 & bus.b[I2+F2-1]}}, bus.b};
    assign w_a_al  = w_a_ext << (c_WF - F1);
    assign w_b_al  = w_b_ext << (c_WF - F2);

    fp_sat #(.W(c_W), .WF(c_WF), .I3(I3), .F3(F3)) u_sat (
        .i_d         (r_d),
        .o_c         (w_c),
        .o_overflow  (w_ovf),
        .o_underflow (w_unf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_a_al <= '0;
            r_b_al <= '0;
            r_d    <= '0;
            r_c    <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else if (!w_stall) begin
            r_v1   <= bus.in_valid;
            r_a_al <= w_a_al;
            r_b_al <= w_b_al;
            r_v2   <= r_v1;
            r_d    <= r_a_al - r_b_al;
            r_v3   <= r_v2;
            r_c    <= w_c;
            r_ovf  <= w_ovf;
            r_unf  <= w_unf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (bus.ovf_clr) begin
            r_cnt <= '0;
        end else if (r_v3 && bus.out_ready && r_ovf && (r_cnt != {c_CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.out_valid = r_v3;
    assign bus.c         = r_c;
    assign bus.sign      = r_c[c_N-1];
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_unf;
    assign bus.ovf_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fp_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_sub_pipe
// Purpose  : Directed self-checking bench with integer reference model
// Revision : 1.0
// ============================================================================
module tb_fp_sub_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_sub_pipe_if bus0 ();
    fp_sub_pipe_if #(.F3(12)) bus1 ();

    fp_sub_pipe dut0 (.clk(clk), .rst(rst), .bus(bus0));
    fp_sub_pipe #(.F3(12)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.a         = bus0.a;
    assign bus1.s1        = bus0.s1;
    assign bus1.b         = bus0.b;
    assign bus1.s2        = bus0.s2;
    assign bus1.out_ready = 1'b1;
    assign bus1.ovf_clr   = bus0.ovf_clr;

    typedef struct {
        logic [15:0] c;
        logic        s, o, u;
        logic        le;
        logic [15:0] lc;
        logic        lo, lu;
        logic        lat;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Literal expectations attached to the beat currently being driven.
    logic        lit_en = 0, lit_o = 0, lit_u = 0, lit_lat = 0;
    logic [15:0] lit_c = 0;
    logic        lit1_en = 0, lit1_u = 0;
    logic [15:0] lit1_c = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Exact difference in units of 2^-14, rescaled to 2^-f3, then clamped.
    function automatic void model(input logic [15:0] a, input logic s1, input logic [15:0] b,
                                  input logic s2, input int f3,
                                  output logic [15:0] c, output logic o, output logic u);
        longint va, vb, d, t, hi, lo;
        int n;
        va = s1 ? longint'($signed(a)) : longint'(a);
        vb = s2 ? longint'($signed(b)) : longint'(b);
        d  = va - vb;
        n  = 2 + f3;
        u  = 1'b0;
        o  = 1'b0;
        if (f3 < 14) begin
            t = d >>> (14 - f3);
            u = (d != (t <<< (14 - f3)));
        end else begin
            t = d <<< (f3 - 14);
        end
        hi = (longint'(1) <<< (n - 1)) - 1;
        lo = -(longint'(1) <<< (n - 1));
        if (t > hi) begin t = hi; o = 1'b1; end
        else if (t < lo) begin t = lo; o = 1'b1; end
        if (o) u = 1'b0;
        c = 16'(t & ((longint'(1) <<< n) - 1));
    endfunction

    int   m_cnt = 0;
    int   out_n0 = 0;
    logic prev_stall = 0;
    logic [15:0] prev_c = 0;

    always @(negedge clk) begin
        exp_t e;
        logic hs_ovf;
        hs_ovf = 1'b0;
        if (rst) begin
            q0.delete();
            m_cnt = 0;
            prev_stall = 0;
        end else begin
            chk("ovf_count", bus0.ovf_count, m_cnt);
            if (prev_stall) chk("stall_hold_c", bus0.c, prev_c);
            if (bus0.in_valid && bus0.in_ready) begin
                model(bus0.a, bus0.s1, bus0.b, bus0.s2, 14, e.c, e.o, e.u);
                e.s = e.c[15];
                e.le = lit_en; e.lc = lit_c; e.lo = lit_o; e.lu = lit_u;
                e.lat = lit_lat; e.cyc = cyc;
                q0.push_back(e);
            end
            if (bus0.out_valid && bus0.out_ready) begin
                out_n0++;
                if (q0.size() == 0) begin
                    chk("spurious_out", bus0.out_valid, 1'b0);
                end else begin
                    e = q0.pop_front();
                    hs_ovf = e.o;
                    chk("c", bus0.c, e.c);
                    chk("sign", bus0.sign, e.s);
                    chk("overflow", bus0.overflow, e.o);
                    chk("underflow", bus0.underflow, e.u);
                    if (e.le) begin
                        chk("lit_c", bus0.c, e.lc);
                        chk("lit_overflow", bus0.overflow, e.lo);
                        chk("lit_underflow", bus0.underflow, e.lu);
                    end
                    if (e.lat) chk("latency", cyc - e.cyc, 3);
                end
            end
            if (bus0.ovf_clr) m_cnt = 0;
            else if (hs_ovf && m_cnt < 255) m_cnt++;
            prev_stall = bus0.out_valid && !bus0.out_ready;
            prev_c = bus0.c;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q1.delete();
        end else begin
            if (bus1.in_valid && bus1.in_ready) begin
                model(bus0.a, bus0.s1, bus0.b, bus0.s2, 12, e.c, e.o, e.u);
                e.s = e.c[13];
                e.le = lit1_en; e.lc = lit1_c; e.lo = 1'b0; e.lu = lit1_u;
                e.lat = 1'b0; e.cyc = cyc;
                q1.push_back(e);
            end
            if (bus1.out_valid) begin
                if (q1.size() == 0) begin
                    chk("f12_spurious_out", bus1.out_valid, 1'b0);
                end else begin
                    e = q1.pop_front();
                    chk("f12_c", bus1.c, e.c);
                    chk("f12_sign", bus1.sign, e.s);
                    chk("f12_overflow", bus1.overflow, e.o);
                    chk("f12_underflow", bus1.underflow, e.u);
                    if (e.le) begin
                        chk("f12_lit_c", bus1.c, e.lc);
                        chk("f12_lit_underflow", bus1.underflow, e.lu);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic s1, input logic [15:0] b, input logic s2,
                        input logic le, input logic [15:0] lc, input logic lo, input logic lu,
                        input logic l1e, input logic [15:0] l1c, input logic l1u);
        bus0.in_valid = 1'b1;
        bus0.a = a; bus0.s1 = s1; bus0.b = b; bus0.s2 = s2;
        lit_en = le; lit_c = lc; lit_o = lo; lit_u = lu; lit_lat = le;
        lit1_en = l1e; lit1_c = l1c; lit1_u = l1u;
        tick();
        bus0.in_valid = 1'b0;
        lit_en = 0; lit_lat = 0; lit1_en = 0;
    endtask

    logic [15:0] bp_a [6] = '{16'h7000, 16'h1234, 16'h8000, 16'h0FFF, 16'h5555, 16'hFFFF};
    logic [15:0] bp_b [6] = '{16'hC000, 16'h4321, 16'h0001, 16'h1000, 16'hAAAA, 16'h0001};
    logic        bp_s1[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        bp_s2[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, acc_n, guard, out_before;
        logic acc;
        bus0.in_valid = 0; bus0.a = 0; bus0.s1 = 0; bus0.b = 0; bus0.s2 = 0;
        bus0.out_ready = 1; bus0.ovf_clr = 0;
        rst = 1;
        tick(); tick();
        @(negedge clk);
        chk("rst_out_valid", bus0.out_valid, 1'b0);
        chk("rst_in_ready", bus0.in_ready, 1'b1);
        chk("rst_c", bus0.c, 16'h0000);
        chk("rst_flags", {bus0.sign, bus0.overflow, bus0.underflow}, 3'b000);
        chk("rst_ovf_count", bus0.ovf_count, 8'd0);
        @(posedge clk); #1;
        rst = 0;

        // Directed vectors with literal results.
        send(16'h4000, 0, 16'h2000, 0, 1, 16'h2000, 0, 0, 0, 0, 0);
        send(16'h2000, 0, 16'h4000, 0, 1, 16'hE000, 0, 0, 0, 0, 0);
        send(16'h7FFF, 1, 16'h8000, 1, 1, 16'h7FFF, 1, 0, 0, 0, 0);
        send(16'h8000, 1, 16'h4000, 0, 1, 16'h8000, 1, 0, 0, 0, 0);
        send(16'h0001, 0, 16'h0000, 0, 1, 16'h0001, 0, 0, 1, 16'h0000, 1);
        send(16'h0004, 0, 16'h0000, 0, 1, 16'h0004, 0, 0, 1, 16'h0001, 0);
        repeat (5) tick();
        @(negedge clk);
        chk("lit_ovf_count_2", bus0.ovf_count, 8'd2);
        @(posedge clk); #1;
        bus0.ovf_clr = 1;
        tick();
        bus0.ovf_clr = 0;
        @(negedge clk);
        chk("lit_ovf_count_clr", bus0.ovf_count, 8'd0);
        @(posedge clk); #1;

        // Backpressure: six beats offered while the output is blocked.
        out_before = out_n0;
        bus0.out_ready = 0;
        idx = 0; acc_n = 0;
        for (int cy = 0; cy < 8; cy++) begin
            bus0.in_valid = 1;
            bus0.a = bp_a[idx]; bus0.s1 = bp_s1[idx]; bus0.b = bp_b[idx]; bus0.s2 = bp_s2[idx];
            @(negedge clk);
            chk("bp_in_ready", bus0.in_ready, (cy < 3));
            acc = bus0.in_ready;
            if (acc) acc_n++;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        chk("bp_accepted", acc_n, 3);
        bus0.out_ready = 1;
        guard = 0;
        while (idx < 6 && guard < 50) begin
            bus0.in_valid = 1;
            bus0.a = bp_a[idx]; bus0.s1 = bp_s1[idx]; bus0.b = bp_b[idx]; bus0.s2 = bp_s2[idx];
            @(negedge clk);
            acc = bus0.in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            guard++;
        end
        bus0.in_valid = 0;
        guard = 0;
        while (q0.size() != 0 && guard < 30) begin tick(); guard++; end
        chk("bp_drain_timeout", q0.size(), 0);
        chk("bp_outputs", out_n0 - out_before, 6);

        // Reset with two beats in flight.
        send(16'h7FFF, 1, 16'h8000, 1, 0, 0, 0, 0, 0, 0, 0);
        send(16'h1000, 0, 16'h0800, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        tick();
        rst = 0;
        bus0.in_valid = 1;
        bus0.a = 16'h3000; bus0.s1 = 0; bus0.b = 16'h1000; bus0.s2 = 0;
        lit_en = 1; lit_c = 16'h2000; lit_o = 0; lit_u = 0; lit_lat = 1;
        @(negedge clk);
        chk("post_rst_out_valid", bus0.out_valid, 1'b0);
        chk("post_rst_flags", {bus0.overflow, bus0.underflow}, 2'b00);
        chk("post_rst_ovf_count", bus0.ovf_count, 8'd0);
        chk("post_rst_in_ready", bus0.in_ready, 1'b1);
        @(posedge clk); #1;
        bus0.in_valid = 0; lit_en = 0; lit_lat = 0;

        guard = 0;
        while ((q0.size() != 0 || q1.size() != 0) && guard < 30) begin tick(); guard++; end
        chk("final_drain_timeout", q0.size() + q1.size(), 0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
